enemy_ai: RTL and testbench

Autonomous controller that drives the enemy fighter's movement command inputs (right, left, jump, squat, defend) from the current player and enemy state. It sits upstream of the enemy position/state block, on the same frame clock. It also replaces the second-player buttons when the game runs in single-player mode. Decisions come from a distance-driven FSM with hold timers and an LFSR tie-breaker.

---
 rtl/game_pkg.sv | 31 +++
 rtl/lfsr16.sv | 24 ++
 rtl/enemy_ai.sv | 157 +++++++++++++++
 tb/tb_enemy_ai.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared game constants and AI types: playfield geometry, enemy AI state encoding and default AI timing.
// Pure declarations, no logic.
package game_pkg;

    localparam int MAP_X    = 640;
    localparam int PLAYER_X = 64;
    localparam int LIMIT_X  = 384;

    localparam int AI_DEF_HOLD     = 16;
    localparam int AI_SQ_HOLD      = 12;
    localparam int AI_MOVE_HOLD    = 8;
    localparam int AI_IDLE_HOLD    = 6;
    localparam int AI_JUMP_TIMEOUT = 64;
    localparam int AI_THREAT_RANGE = 120;
    localparam int AI_NEAR_RANGE   = 80;
    localparam int AI_FAR_RANGE    = 200;

    localparam logic [15:0] AI_LFSR_SEED = 16'hACE1;
    localparam logic [15:0] AI_LFSR_MASK = 16'hB400;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        APPROACH  = 3'd1,
        RETREAT   = 3'd2,
        DEFEND    = 3'd3,
        SQUAT     = 3'd4,
        JUMP_GO   = 3'd5,
        JUMP_WAIT = 3'd6
    } ai_state_t;

endpackage

// File: rtl/lfsr16.sv
// 16-bit right-shifting Galois LFSR, free-running from reset; q is the current (pre-advance) value.
// One step per clock, no stall input.
module lfsr16 #(
    parameter logic [15:0] SEED = 16'hACE1,
    parameter logic [15:0] MASK = 16'hB400
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [15:0] q
);

    logic [15:0] r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= SEED;
        end else begin
            r_q <= {1'b0, r_q[15:1]} ^ (r_q[0] ? MASK : 16'h0000);
        end
    end

    assign q = r_q;

endmodule

// File: rtl/enemy_ai.sv
// Enemy fighter autopilot: distance-driven FSM with hold timers and LFSR tie-breaks.
// Commands are a pure decode of the registered state (1-cycle latency); no backpressure.
module enemy_ai
    import game_pkg::*;
#(
    parameter int          DEF_HOLD     = AI_DEF_HOLD,
    parameter int          SQ_HOLD      = AI_SQ_HOLD,
    parameter int          MOVE_HOLD    = AI_MOVE_HOLD,
    parameter int          IDLE_HOLD    = AI_IDLE_HOLD,
    parameter int          JUMP_TIMEOUT = AI_JUMP_TIMEOUT,
    parameter int          THREAT_RANGE = AI_THREAT_RANGE,
    parameter int          NEAR_RANGE   = AI_NEAR_RANGE,
    parameter int          FAR_RANGE    = AI_FAR_RANGE,
    parameter logic [15:0] LFSR_SEED    = AI_LFSR_SEED
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic signed [10:0] player_x,
    input  logic               player_atk,
    input  logic signed [10:0] enemy_x,
    input  logic               enemy_isJ,
    output logic               right,
    output logic               left,
    output logic               jump,
    output logic               squat,
    output logic               defend
);

    localparam logic signed [11:0] THR_LIM   = 12'(THREAT_RANGE);
    localparam logic signed [11:0] NEAR_LIM  = 12'(NEAR_RANGE);
    localparam logic signed [11:0] FAR_LIM   = 12'(FAR_RANGE);
    localparam logic signed [11:0] APPR_WALL = 12'(MAP_X - LIMIT_X);
    localparam logic signed [11:0] RETR_WALL = 12'(MAP_X - PLAYER_X);

    localparam logic [7:0] H_DEF  = 8'(DEF_HOLD - 1);
    localparam logic [7:0] H_SQ   = 8'(SQ_HOLD - 1);
    localparam logic [7:0] H_MOVE = 8'(MOVE_HOLD - 1);
    localparam logic [7:0] H_IDLE = 8'(IDLE_HOLD - 1);
    localparam logic [7:0] H_JUMP = 8'(JUMP_TIMEOUT - 1);

    ai_state_t          state_r;
    ai_state_t          w_state_nxt;
    ai_state_t          w_dec_state;
    logic [7:0]         hold_r;
    logic [7:0]         w_hold_nxt;
    logic [7:0]         w_dec_hold;
    logic               w_decide;
    logic               r_isj;
    logic [15:0]        w_lfsr;
    logic               w_lfsr_unused;
    logic signed [11:0] w_ex;
    logic signed [11:0] w_dx_raw;
    logic signed [11:0] w_dx;
    logic               w_threat;
    logic               w_appr_blk;
    logic               w_retr_blk;
    logic               w_land;

    lfsr16 #(
        .SEED (LFSR_SEED),
        .MASK (AI_LFSR_MASK)
    ) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .q     (w_lfsr)
    );

    assign w_lfsr_unused = ^w_lfsr[15:3];

    // Enemy to the left of the player gives negative dx, treated as touching.
    assign w_ex       = {enemy_x[10], enemy_x};
    assign w_dx_raw   = w_ex - {player_x[10], player_x};
    assign w_dx       = w_dx_raw[11] ? 12'sd0 : w_dx_raw;
    assign w_threat   = player_atk && (w_dx <= THR_LIM) && !enemy_isJ;
    assign w_appr_blk = (w_ex <= APPR_WALL);
    assign w_retr_blk = (w_ex >= RETR_WALL);
    assign w_land     = r_isj && !enemy_isJ;

    always_comb begin
        w_dec_state = IDLE;
        w_dec_hold  = H_IDLE;
        if (w_threat) begin
            case (w_lfsr[1:0])
                2'b10: begin
                    w_dec_state = JUMP_GO;
                    w_dec_hold  = 8'd0;
                end
                2'b11: begin
                    w_dec_state = SQUAT;
                    w_dec_hold  = H_SQ;
                end
                default: begin
                    w_dec_state = DEFEND;
                    w_dec_hold  = H_DEF;
                end
            endcase
        end else if (w_dx > FAR_LIM) begin
            if (!w_appr_blk) begin
                w_dec_state = APPROACH;
                w_dec_hold  = H_MOVE;
            end
        end else if (w_dx < NEAR_LIM) begin
            if (!w_retr_blk) begin
                w_dec_state = RETREAT;
                w_dec_hold  = H_MOVE;
            end
        end else if (w_lfsr[2] && !w_appr_blk) begin
            w_dec_state = APPROACH;
            w_dec_hold  = H_MOVE;
        end
    end

    // Movement/idle states yield to a threat at once; committed actions run to completion.
    always_comb begin
        w_state_nxt = state_r;
        w_hold_nxt  = hold_r - 8'd1;
        w_decide    = 1'b0;
        case (state_r)
            IDLE, APPROACH, RETREAT: w_decide = w_threat || (hold_r == 8'd0);
            DEFEND, SQUAT:           w_decide = (hold_r == 8'd0);
            JUMP_GO: begin
                w_state_nxt = JUMP_WAIT;
                w_hold_nxt  = H_JUMP;
            end
            JUMP_WAIT:               w_decide = w_land || (hold_r == 8'd0);
            default:                 w_decide = 1'b1;
        endcase
        if (w_decide) begin
            w_state_nxt = w_dec_state;
            w_hold_nxt  = w_dec_hold;
        end
        if (!en) begin
            w_state_nxt = IDLE;
            w_hold_nxt  = 8'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            hold_r  <= 8'd0;
            r_isj   <= 1'b0;
        end else begin
            state_r <= w_state_nxt;
            hold_r  <= w_hold_nxt;
            r_isj   <= enemy_isJ;
        end
    end

    assign left   = (state_r == APPROACH);
    assign right  = (state_r == RETREAT);
    assign defend = (state_r == DEFEND);
    assign squat  = (state_r == SQUAT);
    assign jump   = (state_r == JUMP_GO);

endmodule

// File: tb/tb_enemy_ai.sv
// Directed bench for enemy_ai: approach/retreat holds, walls, threat responses, jump landing/timeout, en and reset.
module tb_enemy_ai;
    import game_pkg::*;

    logic               clk        = 1'b0;
    logic               rst_n      = 1'b0;
    logic               en         = 1'b0;
    logic signed [10:0] player_x   = '0;
    logic               player_atk = 1'b0;
    logic signed [10:0] enemy_x    = '0;
    logic               enemy_isJ  = 1'b0;
    logic               right, left, jump, squat, defend;
    logic [4:0]         w_out;
    logic [15:0]        m_lfsr;
    int                 n_chk = 0;
    int                 n_fail = 0;
    int                 onehot_viol = 0;
    int                 cnt;
    logic               ok;
    ai_state_t          exp_st;

    always #5 clk = ~clk;

    enemy_ai dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .player_x   (player_x),
        .player_atk (player_atk),
        .enemy_x    (enemy_x),
        .enemy_isJ  (enemy_isJ),
        .right      (right),
        .left       (left),
        .jump       (jump),
        .squat      (squat),
        .defend     (defend)
    );

    assign w_out = {right, left, jump, squat, defend};

    // Reference Galois LFSR: shift right, tap mask B400, seed ACE1.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_lfsr <= 16'hACE1;
        else        m_lfsr <= {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
    end

    always @(negedge clk) begin
        if (!$onehot0(w_out)) onehot_viol++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic restart();
        en = 1'b0;
        tick();
        en = 1'b1;
    endtask

    // Wait (bounded) until the enemy is approaching and the next decision will see lfsr[1:0] == tgt.
    task automatic find_approach(input logic [1:0] tgt, output logic found);
        found = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (left && (m_lfsr[1:0] == tgt)) begin
                found = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic attack_pulse();
        player_atk = 1'b1;
        tick();
        player_atk = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out", 32'(w_out), 32'h0);
        chk("rst_state", 32'(dut.state_r), 32'(IDLE));
        chk("rst_lfsr", 32'(dut.w_lfsr), 32'hACE1);
        rst_n = 1'b1;
        tick();
        chk("lfsr_step1", 32'(dut.w_lfsr), 32'hE270);

        // Approach: dx = 500
        en = 1'b1; enemy_x = 11'sd600; player_x = 11'sd100;
        tick();
        chk("appr_first", 32'(w_out), 32'b01000);
        chk("appr_hold7", 32'(dut.hold_r), 32'd7);
        cnt = 1;
        repeat (7) begin tick(); if (w_out == 5'b01000) cnt++; end
        chk("appr_len", cnt, 8);
        chk("appr_hold0", 32'(dut.hold_r), 32'd0);
        tick();
        chk("appr_reload", 32'(dut.hold_r), 32'd7);
        chk("appr_cont", 32'(w_out), 32'b01000);
        enemy_x = 11'(MAP_X - LIMIT_X);
        repeat (10) tick();
        cnt = 0;
        repeat (20) begin tick(); if (w_out != 5'b0) cnt++; end
        chk("appr_wall_quiet", cnt, 0);
        chk("appr_wall_state", 32'(dut.state_r), 32'(IDLE));

        // Retreat: dx = 50
        en = 1'b0; tick();
        en = 1'b1; enemy_x = 11'sd300; player_x = 11'sd250;
        tick();
        chk("retr_first", 32'(w_out), 32'b10000);
        cnt = 1;
        repeat (7) begin tick(); if (w_out == 5'b10000) cnt++; end
        chk("retr_len", cnt, 8);
        tick();
        chk("retr_again", 32'(w_out), 32'b10000);
        chk("retr_reload", 32'(dut.hold_r), 32'd7);
        repeat (3) tick();
        en = 1'b0;
        tick();
        chk("en_low_out", 32'(w_out), 32'h0);
        chk("en_low_state", 32'(dut.state_r), 32'(IDLE));
        enemy_x = 11'(MAP_X - PLAYER_X); player_x = 11'(MAP_X - PLAYER_X - 50); en = 1'b1;
        cnt = 0;
        repeat (20) begin tick(); if (right) cnt++; end
        chk("retr_wall", cnt, 0);

        // Threat responses at dx = 100
        enemy_x = 11'sd300; player_x = 11'sd200;
        restart();
        find_approach(2'b00, ok);
        chk("find_def", 32'(ok), 32'd1);
        attack_pulse();
        chk("def_resp", 32'(w_out), 32'b00001);
        cnt = 1;
        for (int i = 0; i < 15; i++) begin
            player_atk = (i == 4);
            tick();
            if (defend) cnt++;
        end
        player_atk = 1'b0;
        chk("def_len", cnt, 16);
        tick();
        chk("def_end", 32'(defend), 32'd0);

        restart();
        find_approach(2'b11, ok);
        chk("find_sq", 32'(ok), 32'd1);
        attack_pulse();
        chk("sq_resp", 32'(w_out), 32'b00010);
        cnt = 1;
        repeat (11) begin tick(); if (squat) cnt++; end
        chk("sq_len", cnt, 12);
        tick();
        chk("sq_end", 32'(squat), 32'd0);

        // Jump, landing after 20 cycles of waiting
        restart();
        find_approach(2'b10, ok);
        chk("find_jmp", 32'(ok), 32'd1);
        attack_pulse();
        chk("jmp_resp", 32'(w_out), 32'b00100);
        enemy_isJ = 1'b1;
        tick();
        chk("jmp_1cyc", 32'(w_out), 32'h0);
        chk("jw_enter", 32'(dut.state_r), 32'(JUMP_WAIT));
        cnt = 0;
        repeat (19) begin
            tick();
            if (dut.state_r == JUMP_WAIT && w_out == 5'b0) cnt++;
        end
        chk("jw_wait", cnt, 19);
        enemy_isJ = 1'b0;
        exp_st = m_lfsr[2] ? APPROACH : IDLE;
        tick();
        chk("jw_land_exit", 32'(dut.state_r), 32'(exp_st));

        // Jump, enemy never lands: timeout
        restart();
        find_approach(2'b10, ok);
        chk("find_jmp2", 32'(ok), 32'd1);
        attack_pulse();
        chk("jmp2_resp", 32'(w_out), 32'b00100);
        enemy_isJ = 1'b1;
        tick();
        cnt = 0;
        repeat (63) begin tick(); if (dut.state_r == JUMP_WAIT) cnt++; end
        chk("jto_wait", cnt, 63);
        exp_st = m_lfsr[2] ? APPROACH : IDLE;
        tick();
        chk("jto_exit", 32'(dut.state_r), 32'(exp_st));
        enemy_isJ = 1'b0;

        // Asynchronous reset in the middle of a block
        restart();
        find_approach(2'b00, ok);
        chk("find_def2", 32'(ok), 32'd1);
        attack_pulse();
        chk("def2_resp", 32'(w_out), 32'b00001);
        repeat (3) tick();
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out", 32'(w_out), 32'h0);
        chk("arst_state", 32'(dut.state_r), 32'(IDLE));
        chk("arst_lfsr", 32'(dut.w_lfsr), 32'hACE1);
        #10 rst_n = 1'b1;
        repeat (2) tick();

        chk("onehot0", onehot_viol, 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
